// File: rtl/ternary_word_unit.sv
// Trit-serial ternary word unit: MIN, MAX, ANY (saturating sum) or balanced-ternary ADD
// over TRITS-wide words, TPC trits per cycle, LSB chunk first, valid/ready on both sides.

module ternary_trit_cell (
    input  logic [1:0] op,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] cin,
    output logic [1:0] r,
    output logic [1:0] cout,
    output logic       bad
);
    logic [1:0] ac, bc;
    logic [2:0] u2, u3;

    // Encodings are monotonic in trit value, so MIN/MAX compare encodings directly and the
    // offset sums u2/u3 are the true sums shifted by +2/+3.
    always_comb begin
        bad  = (a == 2'b11) || (b == 2'b11);
        ac   = (a == 2'b11) ? 2'b01 : a;
        bc   = (b == 2'b11) ? 2'b01 : b;
        u2   = 3'(ac) + 3'(bc);
        u3   = u2 + 3'(cin);
        r    = 2'b01;
        cout = 2'b01;
        case (op)
            2'b00: r = (ac < bc) ? ac : bc;
            2'b01: r = (ac > bc) ? ac : bc;
            2'b10: r = (u2 < 3'd2) ? 2'b00 : (u2 == 3'd2) ? 2'b01 : 2'b10;
            default: begin
                case (u3)
                    3'd0:    begin r = 2'b01; cout = 2'b00; end
                    3'd1:    begin r = 2'b10; cout = 2'b00; end
                    3'd2:    begin r = 2'b00; cout = 2'b01; end
                    3'd3:    begin r = 2'b01; cout = 2'b01; end
                    3'd4:    begin r = 2'b10; cout = 2'b01; end
                    3'd5:    begin r = 2'b00; cout = 2'b10; end
                    default: begin r = 2'b01; cout = 2'b10; end
                endcase
            end
        endcase
    end
endmodule

module ternary_word_unit #(
    parameter int TRITS = 8,
    parameter int TPC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [2*TRITS-1:0] a,
    input  logic [2*TRITS-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*TRITS-1:0] result,
    output logic [1:0]         carry,
    output logic               err
);
    localparam int NCH = TRITS / TPC;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic [1:0] TZERO = 2'b01;

    if (TPC < 1 || (TRITS % TPC) != 0) begin : g_bad_cfg
        $error("ternary_word_unit: TRITS must be a multiple of TPC");
    end

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [2*TRITS-1:0]   a_q, b_q;
    logic [1:0]           op_q, cry;
    logic [TPC-1:0][1:0]  ca, cb, cr;
    logic [TPC-1:0]       cbad;
    logic [1:0]           cc [TPC+1];
    int                   base;
    logic                 last;

    always_comb base = int'(cnt) * 2 * TPC;
    assign ca    = a_q[base +: 2*TPC];
    assign cb    = b_q[base +: 2*TPC];
    assign cc[0] = cry;
    assign last  = (cnt == CW'(NCH - 1));

    // Carry ripples through the chunk's cells; cc[TPC] is registered for the next chunk.
    for (genvar i = 0; i < TPC; i++) begin : g_cell
        ternary_trit_cell u_cell (
            .op  (op_q),
            .a   (ca[i]),
            .b   (cb[i]),
            .cin (cc[i]),
            .r   (cr[i]),
            .cout(cc[i+1]),
            .bad (cbad[i])
        );
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 2'b00;
            cry    <= TZERO;
            result <= {TRITS{TZERO}};
            carry  <= TZERO;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    op_q  <= op;
                    cnt   <= '0;
                    err   <= 1'b0;
                    cry   <= TZERO;
                    state <= RUN;
                end
                RUN: begin
                    result[base +: 2*TPC] <= cr;
                    err <= err | (|cbad);
                    cry <= cc[TPC];
                    if (last) begin
                        carry <= cc[TPC];
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ternary_word_unit.sv
// Bench for ternary_word_unit: directed vectors, stall/abort handling, TPC variants and
// randomized ops against an integer-arithmetic balanced-ternary model.

module tb_ternary_word_unit;
    localparam int T = 4;

    logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [2*T-1:0] a = '0, b = '0;
    logic           in_ready, out_valid, err;
    logic [2*T-1:0] result;
    logic [1:0]     carry;
    logic           in_ready2, out_valid2, err2, in_ready4, out_valid4, err4;
    logic [2*T-1:0] result2, result4;
    logic [1:0]     carry2, carry4;

    int checks = 0;
    int passed = 0;

    ternary_word_unit #(.TRITS(T), .TPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry), .err(err));
    ternary_word_unit #(.TRITS(T), .TPC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .op(op), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .carry(carry2), .err(err2));
    ternary_word_unit #(.TRITS(T), .TPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .op(op), .a(a), .b(b),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .carry(carry4), .err(err4));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: decode trits to integers, compute with plain arithmetic, re-encode.
    function automatic void ref_model(input logic [1:0] o, input logic [2*T-1:0] x, input logic [2*T-1:0] y,
                                      output logic [2*T-1:0] r, output logic [1:0] c, output logic e);
        int cv, xv, yv, s, rv;
        logic [1:0] tx, ty;
        cv = 0; e = 1'b0; r = '0;
        for (int i = 0; i < T; i++) begin
            tx = x[2*i +: 2];
            ty = y[2*i +: 2];
            if (tx == 2'b11) begin e = 1'b1; xv = 0; end else xv = int'(tx) - 1;
            if (ty == 2'b11) begin e = 1'b1; yv = 0; end else yv = int'(ty) - 1;
            case (o)
                2'b00: rv = (xv < yv) ? xv : yv;
                2'b01: rv = (xv > yv) ? xv : yv;
                2'b10: begin s = xv + yv; rv = (s > 1) ? 1 : (s < -1) ? -1 : s; end
                default: begin
                    s  = xv + yv + cv;
                    rv = ((s + 4) % 3) - 1;
                    cv = (s - rv) / 3;
                end
            endcase
            r[2*i +: 2] = 2'(rv + 1);
        end
        c = (o == 2'b11) ? 2'(cv + 1) : 2'b01;
    endfunction

    // All tasks are entered and left at 1 time unit after a rising edge.
    task automatic accept(input logic [1:0] o, input logic [2*T-1:0] x, input logic [2*T-1:0] y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            op = o; a = x; b = y; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if ({in_ready, out_valid} !== 2'b00) $display("FAIL reset_hs got %b exp 00", {in_ready, out_valid}); else passed++;
        checks++; if (result !== 8'h55) $display("FAIL reset_result got %h exp 55", result); else passed++;
        checks++; if ({carry, err} !== 3'b010) $display("FAIL reset_carry_err got %b exp 010", {carry, err}); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_idle_ready got %b exp 1", in_ready); else passed++;
    endtask

    task automatic test_directed();
        logic [1:0]     ops [5] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11};
        logic [2*T-1:0] va  [5] = '{8'b10_01_00_10, 8'b10_01_00_10, 8'b10_01_00_10, 8'b10_01_00_10, 8'b10_10_10_10};
        logic [2*T-1:0] vb  [5] = '{8'b00_01_10_10, 8'b00_01_10_10, 8'b00_01_10_10, 8'b00_01_10_10, 8'b01_01_01_10};
        logic [2*T-1:0] er  [5] = '{8'b00_01_00_10, 8'b01_01_01_10, 8'b10_01_10_10, 8'b01_01_10_00, 8'b00_00_00_00};
        logic [1:0]     ec  [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        bit ok; int lat;
        for (int k = 0; k < 5; k++) begin
            accept(ops[k], va[k], vb[k], ok);
            checks++; if (!ok) $display("FAIL dir%0d_accept got not-ready exp ready", k); else passed++;
            wait_out(lat);
            checks++; if (lat !== 4) $display("FAIL dir%0d_latency got %0d exp 4", k, lat); else passed++;
            checks++; if (result !== er[k]) $display("FAIL dir%0d_result got %b exp %b", k, result, er[k]); else passed++;
            checks++; if ({carry, err} !== {ec[k], 1'b0}) $display("FAIL dir%0d_carry_err got %b exp %b", k, {carry, err}, {ec[k], 1'b0}); else passed++;
            release_out();
            checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL dir%0d_release got %b exp 01", k, {out_valid, in_ready}); else passed++;
        end
    endtask

    task automatic test_stall();
        bit ok, bad; int lat;
        accept(2'b00, 8'b10_01_00_10, 8'b00_01_10_10, ok);
        wait_out(lat);
        bad = (lat != 4);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin in_valid = 1'b1; op = 2'b11; a = 8'hAA; b = 8'hAA; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (!out_valid || in_ready || result !== 8'b00_01_00_10 || carry !== 2'b01 || err !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL stall_hold got result %b carry %b err %b ov %b ir %b exp stable", result, carry, err, out_valid, in_ready); else passed++;
        release_out();
        checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL stall_release got %b exp 01", {out_valid, in_ready}); else passed++;
        accept(2'b11, 8'b10_10_10_10, 8'b01_01_01_10, ok);
        wait_out(lat);
        checks++; if ({result, carry} !== {8'h00, 2'b10} || lat !== 4) $display("FAIL stall_next got %b/%b lat %0d exp 00000000/10 lat 4", result, carry, lat); else passed++;
        release_out();
    endtask

    task automatic test_illegal();
        bit ok; int lat;
        accept(2'b11, 8'b01_01_01_11, 8'b01_01_01_10, ok);
        wait_out(lat);
        checks++; if ({result, carry, err} !== {8'b01_01_01_10, 2'b01, 1'b1}) $display("FAIL illegal_add got %b %b %b exp 01010110 01 1", result, carry, err); else passed++;
        release_out();
        accept(2'b01, 8'b10_01_00_10, 8'b00_01_10_10, ok);
        wait_out(lat);
        checks++; if ({result, err} !== {8'b10_01_10_10, 1'b0}) $display("FAIL illegal_clear got %b %b exp 10011010 0", result, err); else passed++;
        release_out();
    endtask

    task automatic test_abort();
        bit ok, seen;
        accept(2'b11, 8'b10_10_10_10, 8'b01_01_01_10, ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready, err} !== 3'b000) $display("FAIL abort_hs got %b exp 000", {out_valid, in_ready, err}); else passed++;
        checks++; if ({result, carry} !== {8'h55, 2'b01}) $display("FAIL abort_outputs got %h/%b exp 55/01", result, carry); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) $display("FAIL abort_no_valid got out_valid pulse exp none"); else passed++;
    endtask

    task automatic test_tpc();
        logic [2*T-1:0] va [2] = '{8'b10_01_00_10, 8'b10_10_10_10};
        logic [2*T-1:0] vb [2] = '{8'b00_01_10_10, 8'b01_01_01_10};
        logic [2*T-1:0] er [2] = '{8'b01_01_10_00, 8'b00_00_00_00};
        logic [1:0]     ec [2] = '{2'b01, 2'b10};
        int l2, l4;
        for (int k = 0; k < 2; k++) begin
            checks++; if ({in_ready2, in_ready4} !== 2'b11) $display("FAIL tpc%0d_ready got %b exp 11", k, {in_ready2, in_ready4}); else passed++;
            op = 2'b11; a = va[k]; b = vb[k]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; a = '0; b = '0;
            l2 = -1; l4 = -1;
            for (int i = 1; i <= 8; i++) begin
                if (out_valid2 && l2 < 0) l2 = i - 1;
                if (out_valid4 && l4 < 0) l4 = i - 1;
                @(posedge clk); #1;
            end
            checks++; if (l2 !== 2 || l4 !== 1) $display("FAIL tpc%0d_latency got %0d/%0d exp 2/1", k, l2, l4); else passed++;
            checks++; if ({result2, carry2, err2} !== {er[k], ec[k], 1'b0}) $display("FAIL tpc%0d_tpc2 got %b %b %b exp %b %b 0", k, result2, carry2, err2, er[k], ec[k]); else passed++;
            checks++; if ({result4, carry4, err4} !== {er[k], ec[k], 1'b0}) $display("FAIL tpc%0d_tpc4 got %b %b %b exp %b %b 0", k, result4, carry4, err4, er[k], ec[k]); else passed++;
            release_out();
        end
    endtask

    task automatic test_random();
        logic [1:0] o; logic [2*T-1:0] x, y, er; logic [1:0] ec; logic ee;
        bit ok; int lat;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            x = 8'($urandom);
            y = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 0; i < T; i++) begin
                    if (x[2*i +: 2] == 2'b11) x[2*i +: 2] = 2'($urandom_range(0, 2));
                    if (y[2*i +: 2] == 2'b11) y[2*i +: 2] = 2'($urandom_range(0, 2));
                end
            end
            ref_model(o, x, y, er, ec, ee);
            accept(o, x, y, ok);
            wait_out(lat);
            checks++; if (!ok || lat !== 4) $display("FAIL rnd%0d_latency got %0d exp 4", n, lat); else passed++;
            checks++; if ({result, carry, err} !== {er, ec, ee}) $display("FAIL rnd%0d op %b a %b b %b got %b %b %b exp %b %b %b", n, o, x, y, result, carry, err, er, ec, ee); else passed++;
            for (int s = $urandom_range(0, 2); s > 0; s--) begin @(posedge clk); #1; end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_illegal();
        test_abort();
        test_tpc();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
